intra_delay_scheduler: RTL and testbench
========================================

Name: intra_delay_scheduler

Overview:
- Downstream consumer of the 2-operand producer stage: captures operands a/b on acceptance, evaluates one of four ops immediately, and commits the result to target register x or y after a per-request cycle delay.
- Hardware equivalent of blocking intra-assignment delay (`x = #D expr`): the RHS is evaluated at issue, and delays are sequential, each counted after the previous commit.
- Sits between operand generators and any logic that watches the x/y register pair.

Parameters:
- WIDTH, 4, data width of operands, results and x/y registers
- DEPTH, 4, pending-request FIFO entries (power of two, >=2)
- DLY_W, 5, width of per-request delay field (max delay 2^DLY_W-1 cycles)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request slot free; accept = in_valid && in_ready at rising edge
- in_dest  in  1  0 = x, 1 = y
- in_op  in  2  00 PASS_A, 01 ADD, 10 SUB (a-b), 11 INC (a+1)
- in_a  in  WIDTH  operand a
- in_b  in  WIDTH  operand b
- in_delay  in  DLY_W  cycles to wait before commit
- x_out  out  WIDTH  register x
- y_out  out  WIDTH  register y
- upd_valid  out  1  one-cycle pulse on the cycle after each commit edge
- upd_dest  out  1  destination of the commit, valid with upd_valid
- upd_data  out  WIDTH  committed value, valid with upd_valid
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, rst_n low): x_out, y_out, upd_data = 0; upd_valid, upd_dest, busy = 0; FIFO emptied; FSM = IDLE; cnt = 0; in_ready = 1 after release. All pending requests are discarded. No commit on the first edge after release.
- Accept:
  - result computed combinationally from in_a/in_b at the accept edge, truncated mod 2^WIDTH (SUB wraps, ADD drops carry).
  - {dest, result, delay} pushed into the FIFO.
  - Later changes of in_a/in_b have no effect on that request.
- in_ready = !full. No pop-through: a push into a full FIFO is not permitted even in a pop cycle.
- FSM states:
  - IDLE: if FIFO non-empty, load cnt <= head.delay and go to COUNT. Otherwise stay.
  - COUNT, cnt != 0: cnt <= cnt-1.
  - COUNT, cnt == 0: commit head (write x_out or y_out, pulse upd_*), pop head. If another entry remains after the pop, load cnt <= next.delay and stay in COUNT; else go to IDLE.
- Latency:
  - Request accepted at edge E0 into an idle, empty block commits at edge E0+D+2.
  - A queued request whose predecessor commits at edge Ec commits at Ec+D+1.
  - D = 0 gives back-to-back commits on consecutive edges.
- A request accepted on the same edge that the FSM leaves IDLE for an older head is simply queued behind it.
- Only one commit per edge. The register that is not the destination holds its value.
- upd_valid is high exactly one cycle per commit. It is never high while the FSM is in IDLE with an empty FIFO.
- busy is low only when the FIFO is empty and the FSM is in IDLE.

Decomposition:
- Shared package `sched_pkg`:
  - op encodings OP_PASS/OP_ADD/OP_SUB/OP_INC
  - dest encodings DEST_X/DEST_Y
  - FSM state enum IDLE/COUNT
  - packed entry struct {dest, data, delay}
- Sub-module `sched_fifo`:
  - synchronous FIFO, DEPTH x entry width, async active-low reset
  - push/pop/full/empty/head outputs
  - pointer wrap with an extra MSB for the full/empty distinction
- Top level holds op evaluation, the FSM, the counter and the x/y registers.

Test Plan:
- Reset check: hold rst_n low, then release -> x_out = 0, y_out = 0, in_ready = 1, busy = 0, no upd_valid for 10 idle cycles.
- Single ADD: dest X, ADD, a=3, b=13, delay=4 accepted at E0 -> x_out = 0 (16 mod 16) after edge E6. upd_valid high for exactly one cycle with upd_dest = 0 and upd_data = 0. y_out stays 0.
- Back-to-back requests:
  - Stimulus: E0 accept X ADD a=2, b=1, delay=2; E1 accept Y SUB a=3, b=13, delay=1.
  - Response: x_out = 3 after E4; y_out = 6 after E6.
  - Also: delay 0 on both requests -> commits on consecutive edges.
- Full FIFO:
  - Stimulus: 4 requests with delay=3 on consecutive cycles; hold a 5th with in_valid = 1.
  - Response: in_ready = 0 after the 4th push; the 5th is accepted on the first edge after the first commit; total 5 commits in order.
- Operand capture: accept X PASS a=9, delay=5, then drive in_a = 1 the next cycle -> x_out = 9 at commit.
- Reset mid-COUNT: pulse rst_n low with 3 requests pending -> outputs immediately 0, busy = 0, no commit after release, in_ready = 1.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types for the intra-assignment-delay scheduler: op/dest encodings, FSM state, queue entry.
package sched_pkg;

  localparam int unsigned DataW = 4;
  localparam int unsigned DlyW  = 5;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_INC  = 2'b11
  } op_e;

  localparam logic DEST_X = 1'b0;
  localparam logic DEST_Y = 1'b1;

  typedef enum logic {
    IDLE,
    COUNT
  } state_e;

  typedef struct packed {
    logic             dest;
    logic [DataW-1:0] data;
    logic [DlyW-1:0]  delay;
  } entry_t;

  // Results wrap mod 2^DataW: ADD drops the carry, SUB wraps below zero.
  function automatic logic [DataW-1:0] eval_op(input logic [1:0] op, input logic [DataW-1:0] a,
                                               input logic [DataW-1:0] b);
    logic [DataW-1:0] r;
    case (op)
      OP_PASS: r = a;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      default: r = a + DataW'(1);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Pending-request FIFO; exposes the head and the entry behind it so the FSM can reload without a bubble.
module sched_fifo
  import sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output logic   multi,
  output entry_t head,
  output entry_t second
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d, count;
  entry_t      mem_q [DEPTH];

  // Extra pointer MSB separates full from empty when the address bits match.
  assign count  = wr_q - rd_q;
  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign multi  = (count >= (AW + 1)'(2));
  assign head   = mem_q[rd_q[AW-1:0]];
  assign second = mem_q[rd_q[AW-1:0] + AW'(1)];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push && !full) wr_d = wr_q + (AW + 1)'(1);
    if (pop && !empty) rd_d = rd_q + (AW + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/intra_delay_scheduler.sv
// Evaluates a/b at accept, queues {dest, result, delay}, and commits each result to x or y after
// its delay, counted from the previous commit.
module intra_delay_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned WIDTH = DataW,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DLY_W = DlyW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_dest,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [DLY_W-1:0] in_delay,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic             upd_valid,
  output logic             upd_dest,
  output logic [WIDTH-1:0] upd_data,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, upd_data_q, upd_data_d;
  logic             upd_valid_q, upd_valid_d, upd_dest_q, upd_dest_d;

  logic   push, pop, full, empty, multi;
  entry_t wdata, head, second;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign wdata    = '{dest: in_dest, data: eval_op(in_op, in_a, in_b), delay: in_delay};

  sched_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .multi (multi),
    .head  (head),
    .second(second)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    upd_valid_d = 1'b0;
    upd_dest_d  = upd_dest_q;
    upd_data_d  = upd_data_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          cnt_d   = head.delay;
          state_d = COUNT;
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DLY_W'(1);
        end else begin
          pop         = 1'b1;
          upd_valid_d = 1'b1;
          upd_dest_d  = head.dest;
          upd_data_d  = head.data;
          if (head.dest == DEST_Y) y_d = head.data;
          else                     x_d = head.data;
          // Only entries already queued count; a same-edge push is picked up from IDLE.
          if (multi) cnt_d = second.delay;
          else       state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      upd_valid_q <= 1'b0;
      upd_dest_q  <= 1'b0;
      upd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      upd_valid_q <= upd_valid_d;
      upd_dest_q  <= upd_dest_d;
      upd_data_q  <= upd_data_d;
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign upd_valid = upd_valid_q;
  assign upd_dest  = upd_dest_q;
  assign upd_data  = upd_data_q;
  assign busy      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_intra_delay_scheduler.sv
// Directed bench: table of single requests into an idle block plus hand-written multi-request sequences.
module tb_intra_delay_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_dest = 1'b0;
  logic [1:0] in_op = 2'b00;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [4:0] in_delay = '0;
  logic [3:0] x_out, y_out, upd_data;
  logic       upd_valid, upd_dest, busy;

  intra_delay_scheduler #(
    .WIDTH(4),
    .DEPTH(4),
    .DLY_W(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dest  (in_dest),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_delay (in_delay),
    .x_out    (x_out),
    .y_out    (y_out),
    .upd_valid(upd_valid),
    .upd_dest (upd_dest),
    .upd_data (upd_data)
    ,
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int         e;
    logic       dest;
    logic [3:0] data;
  } rec_t;
  rec_t q[$];

  // Commit log: at the falling edge after commit edge Ec, edge_n equals Ec.
  always @(negedge clk) begin
    if (rst_n && upd_valid) q.push_back('{e: edge_n, dest: upd_dest, data: upd_data});
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic d, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [4:0] dl);
    in_valid = 1'b1;
    in_dest  = d;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_delay = dl;
  endtask

  typedef struct {
    logic       dest;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] dl;
    logic [3:0] res;
    logic [3:0] ex;
    logic [3:0] ey;
  } vec_t;
  vec_t vecs[8];

  int e0, acc;
  int exp_e[5];
  int exp_d[5];

  initial begin
    vecs[0] = '{1'b0, 2'b01, 4'd3,  4'd13, 5'd4,  4'd0,  4'd0, 4'd0};
    vecs[1] = '{1'b1, 2'b10, 4'd3,  4'd13, 5'd1,  4'd6,  4'd0, 4'd6};
    vecs[2] = '{1'b0, 2'b00, 4'd9,  4'd5,  5'd0,  4'd9,  4'd9, 4'd6};
    vecs[3] = '{1'b1, 2'b11, 4'd15, 4'd0,  5'd2,  4'd0,  4'd9, 4'd0};
    vecs[4] = '{1'b0, 2'b11, 4'd7,  4'd0,  5'd31, 4'd8,  4'd8, 4'd0};
    vecs[5] = '{1'b1, 2'b01, 4'd7,  4'd6,  5'd3,  4'd13, 4'd8, 4'd13};
    vecs[6] = '{1'b0, 2'b10, 4'd5,  4'd2,  5'd0,  4'd3,  4'd3, 4'd13};
    vecs[7] = '{1'b1, 2'b00, 4'd10, 4'd3,  5'd5,  4'd10, 4'd3, 4'd10};

    // Reset and idle behaviour
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("reset x_out", x_out, 0);
    chk("reset y_out", y_out, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset no upd_valid", q.size(), 0);

    // Table: one request into an idle block, commit expected at E0+D+2
    for (int i = 0; i < 8; i++) begin
      q.delete();
      @(negedge clk);
      drive(vecs[i].dest, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dl);
      e0 = edge_n + 1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d busy while pending", i), busy, 1);
      repeat (int'(vecs[i].dl) + 4) @(negedge clk);
      chk($sformatf("v%0d commit count", i), q.size(), 1);
      if (q.size() >= 1) begin
        chk($sformatf("v%0d commit edge", i), q[0].e - e0, int'(vecs[i].dl) + 2);
        chk($sformatf("v%0d upd_dest", i), q[0].dest, vecs[i].dest);
        chk($sformatf("v%0d upd_data", i), q[0].data, vecs[i].res);
      end
      chk($sformatf("v%0d x_out", i), x_out, vecs[i].ex);
      chk($sformatf("v%0d y_out", i), y_out, vecs[i].ey);
      chk($sformatf("v%0d busy after", i), busy, 0);
      chk($sformatf("v%0d upd_valid low", i), upd_valid, 0);
    end

    // Back-to-back: second request queued behind the first
    q.delete();
    @(negedge clk);
    drive(1'b0, 2'b01, 4'd2, 4'd1, 5'd2);
    e0 = edge_n + 1;
    @(negedge clk);
    drive(1'b1, 2'b10, 4'd3, 4'd13, 5'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b commits", q.size(), 2);
    if (q.size() >= 2) begin
      chk("b2b first edge", q[0].e - e0, 4);
      chk("b2b second edge", q[1].e - e0, 6);
      chk("b2b second dest", q[1].dest, 1);
    end
    chk("b2b x_out", x_out, 3);
    chk("b2b y_out", y_out, 6);

    // Zero delays commit on consecutive edges
    q.delete();
    @(negedge clk);
    drive(1'b0, 2'b01, 4'd1, 4'd1, 5'd0);
    e0 = edge_n + 1;
    @(negedge clk);
    drive(1'b1, 2'b01, 4'd2, 4'd2, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("d0 commits", q.size(), 2);
    if (q.size() >= 2) begin
      chk("d0 first edge", q[0].e - e0, 2);
      chk("d0 second edge", q[1].e - e0, 3);
    end
    chk("d0 x_out", x_out, 2);
    chk("d0 y_out", y_out, 4);

    // Full FIFO with a held fifth request
    q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(i[0], 2'b00, 4'(i + 1), 4'd0, 5'd3);
      if (i == 0) e0 = edge_n + 1;
    end
    @(negedge clk);
    chk("full in_ready", in_ready, 0);
    drive(1'b1, 2'b00, 4'd5, 4'd0, 5'd3);
    acc = -1;
    for (int k = 0; k < 20 && acc < 0; k++) begin
      if (in_ready) acc = edge_n + 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full 5th accept edge", acc - e0, 6);
    repeat (20) @(negedge clk);
    exp_e = '{5, 9, 13, 17, 21};
    exp_d = '{1, 2, 3, 4, 5};
    chk("full commits", q.size(), 5);
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      chk($sformatf("full c%0d edge", i), q[i].e - e0, exp_e[i]);
      chk($sformatf("full c%0d data", i), q[i].data, exp_d[i]);
    end
    chk("full x_out", x_out, 3);
    chk("full y_out", y_out, 5);

    // Operand capture at accept
    q.delete();
    @(negedge clk);
    drive(1'b0, 2'b00, 4'd9, 4'd0, 5'd5);
    e0 = edge_n + 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 4'd1;
    repeat (8) @(negedge clk);
    chk("capture commits", q.size(), 1);
    if (q.size() >= 1) chk("capture edge", q[0].e - e0, 7);
    chk("capture x_out", x_out, 9);

    // Reset mid-COUNT discards everything
    q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 2'b01, 4'(i), 4'd1, 5'd5);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset x_out", x_out, 0);
    chk("async reset y_out", y_out, 0);
    chk("async reset busy", busy, 0);
    chk("async reset upd_valid", upd_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post-reset no commit", q.size(), 0);
    chk("post-reset in_ready", in_ready, 1);
    chk("post-reset busy", busy, 0);
    chk("post-reset x_out", x_out, 0);
    chk("post-reset y_out", y_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
